// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, instruction field positions, operation classes and control states shared by the core
package proc_pkg;
  localparam logic [5:0] OP_NOP = 6'h00, OP_ADD = 6'h01, OP_SUB = 6'h02, OP_AND = 6'h03, OP_OR = 6'h04,
    OP_XOR = 6'h05, OP_ADDI = 6'h06, OP_SUBI = 6'h07, OP_ANDI = 6'h08, OP_ORI = 6'h09, OP_LOAD = 6'h0A,
    OP_STORE = 6'h0B, OP_SHR = 6'h11, OP_SHL = 6'h12, OP_BR = 6'h20, OP_JMP = 6'h21, OP_BEQ = 6'h22,
    OP_BLT = 6'h23, OP_BGT = 6'h24, OP_HALT = 6'h3F;
  localparam int OP_LSB = 26, RS1_LSB = 21, RS2_LSB = 16, RD_LSB = 11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
  typedef enum logic [2:0] {K_NOP, K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BR, K_JMP, K_HALT} kind_t;
  function automatic kind_t kind_of(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR} ? K_ALU_R
         : op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SHR, OP_SHL} ? K_ALU_I
         : op == OP_LOAD ? K_LOAD
         : op == OP_STORE ? K_STORE
         : op inside {OP_BR, OP_BEQ, OP_BLT, OP_BGT} ? K_BR
         : op == OP_JMP ? K_JMP
         : op == OP_HALT ? K_HALT : K_NOP;
  endfunction
endpackage

// File: rtl/pipelined_core_if.sv
// pipelined_core_if: instruction load, run control, status and debug-read signals of pipelined_core
interface pipelined_core_if #(parameter int DATA_W = 32, parameter int IMEM_AW = 8, parameter int DMEM_AW = 8);
  localparam int DBG_AW = DMEM_AW > 5 ? DMEM_AW : 5;
  logic imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic start;
  logic dbg_sel;
  logic [DBG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;
  logic running;
  logic halted;
  logic [31:0] retired;
  modport master (output imem_we, imem_addr, imem_wdata, start, dbg_sel, dbg_addr,
                  input dbg_rdata, running, halted, retired);
  modport slave (input imem_we, imem_addr, imem_wdata, start, dbg_sel, dbg_addr,
                 output dbg_rdata, running, halted, retired);
endinterface

// File: rtl/proc_regfile.sv
// proc_regfile: 32 x DATA_W registers, r0 fixed at zero, write-through to the two pipeline read ports
module proc_regfile #(parameter int DATA_W = 32) (
  input logic clk1,
  input logic reset,
  input logic we,
  input logic [4:0] waddr,
  input logic [DATA_W-1:0] wdata,
  input logic [4:0] raddr_a,
  input logic [4:0] raddr_b,
  input logic [4:0] dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_rdata
);
  logic [DATA_W-1:0] rf [32];
  logic wr;
  assign wr = we && waddr != 5'd0;
  always_ff @(posedge clk1) begin
    if (reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (wr) rf[waddr] <= wdata;
  end
  assign rdata_a = wr && waddr == raddr_a ? wdata : rf[raddr_a];
  assign rdata_b = wr && waddr == raddr_b ? wdata : rf[raddr_b];
  assign dbg_rdata = rf[dbg_addr];
endmodule

// File: rtl/pipelined_core.sv
// pipelined_core: five-stage in-order core with forwarding, load-use stall and branches resolved in EX
module pipelined_core import proc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input logic clk1,
  input logic reset,
  pipelined_core_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);
  typedef struct packed {
    logic valid; logic [5:0] op; kind_t kind; logic [4:0] rs1, rs2, rd; logic wr;
    logic [DATA_W-1:0] a, b, imm; logic [IMEM_AW-1:0] tgt;
  } id_ex_t;
  typedef struct packed { logic valid; kind_t kind; logic [4:0] rd; logic wr; logic [DATA_W-1:0] res, sd; } ex_mem_t;
  typedef struct packed { logic valid; logic halt; logic [4:0] rd; logic wr; logic [DATA_W-1:0] res; } mem_wb_t;
  state_t state;
  logic [31:0] imem [2**IMEM_AW];
  logic [DATA_W-1:0] dmem [2**DMEM_AW];
  logic [IMEM_AW-1:0] pc, if_pc;
  logic [31:0] if_ir;
  logic if_valid, fetch_stop, run, stall, flush, cond, use_rs1, use_rs2;
  kind_t id_kind;
  logic [4:0] id_rs1, id_rs2;
  logic [DATA_W-1:0] id_imm, rd_a, rd_b, reg_dbg, fa, fb, opnd, alu;
  id_ex_t id_dec, id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  assign run = state == S_RUN;
  assign id_kind = if_valid ? kind_of(if_ir[OP_LSB +: 6]) : K_NOP;
  assign id_rs1 = if_ir[RS1_LSB +: 5];
  assign id_rs2 = if_ir[RS2_LSB +: 5];
  assign id_imm = DATA_W'($signed(if_ir[15:0]));
  always_comb begin
    id_dec = '0;
    id_dec.valid = if_valid;
    id_dec.op = if_ir[OP_LSB +: 6];
    id_dec.kind = id_kind;
    id_dec.rs1 = id_rs1;
    id_dec.rs2 = id_rs2;
    id_dec.rd = id_kind == K_ALU_R ? if_ir[RD_LSB +: 5] : id_rs2;
    id_dec.wr = id_kind inside {K_ALU_R, K_ALU_I, K_LOAD} && id_dec.rd != 5'd0;
    id_dec.a = rd_a;
    id_dec.b = rd_b;
    id_dec.imm = id_imm;
    id_dec.tgt = id_kind == K_JMP ? if_ir[IMEM_AW-1:0] : if_pc + id_imm[IMEM_AW-1:0];
  end
  assign use_rs1 = id_kind inside {K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BR};
  assign use_rs2 = id_kind inside {K_ALU_R, K_STORE} || (id_kind == K_BR && id_dec.op != OP_BR);
  assign stall = id_ex.kind == K_LOAD && id_ex.wr &&
                 ((use_rs1 && id_ex.rd == id_rs1) || (use_rs2 && id_ex.rd == id_rs2));
  // EX/MEM is younger than MEM/WB, so it wins when both target the same register
  assign fa = ex_mem.wr && ex_mem.rd == id_ex.rs1 ? ex_mem.res : mem_wb.wr && mem_wb.rd == id_ex.rs1 ? mem_wb.res : id_ex.a;
  assign fb = ex_mem.wr && ex_mem.rd == id_ex.rs2 ? ex_mem.res : mem_wb.wr && mem_wb.rd == id_ex.rs2 ? mem_wb.res : id_ex.b;
  assign opnd = id_ex.kind == K_ALU_R ? fb : id_ex.imm;
  always_comb begin
    alu = fa + opnd;
    cond = 1'b0;
    case (id_ex.op)
      OP_SUB, OP_SUBI: alu = fa - opnd;
      OP_AND, OP_ANDI: alu = fa & opnd;
      OP_OR, OP_ORI: alu = fa | opnd;
      OP_XOR: alu = fa ^ opnd;
      OP_SHR: alu = fa >> id_ex.imm[SH_W-1:0];
      OP_SHL: alu = fa << id_ex.imm[SH_W-1:0];
      OP_BR: cond = fa == '0;
      OP_JMP: cond = 1'b1;
      OP_BEQ: cond = fa == fb;
      OP_BLT: cond = $signed(fa) < $signed(fb);
      OP_BGT: cond = $signed(fa) > $signed(fb);
      default: ;
    endcase
  end
  assign flush = run && cond;
  proc_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk1(clk1), .reset(reset), .we(run && mem_wb.wr), .waddr(mem_wb.rd), .wdata(mem_wb.res),
    .raddr_a(id_rs1), .raddr_b(id_rs2), .dbg_addr(bus.dbg_addr[4:0]),
    .rdata_a(rd_a), .rdata_b(rd_b), .dbg_rdata(reg_dbg)
  );
  assign bus.dbg_rdata = bus.dbg_sel ? dmem[bus.dbg_addr[DMEM_AW-1:0]] : reg_dbg;
  always_ff @(posedge clk1) begin
    if (bus.imem_we && !run) imem[bus.imem_addr] <= bus.imem_wdata;
    if (run && !reset && ex_mem.valid && ex_mem.kind == K_STORE) dmem[ex_mem.res[DMEM_AW-1:0]] <= ex_mem.sd;
  end
  always_ff @(posedge clk1) begin
    if (reset) begin
      state <= S_IDLE;
      pc <= '0;
      if_pc <= '0;
      if_ir <= {OP_NOP, 26'd0};
      if_valid <= 1'b0;
      fetch_stop <= 1'b0;
      id_ex <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      bus.running <= 1'b0;
      bus.halted <= 1'b0;
      bus.retired <= '0;
    end else if (state == S_IDLE && bus.start) begin
      state <= S_RUN;
      bus.running <= 1'b1;
    end else if (run) begin
      mem_wb <= '{valid: ex_mem.valid, halt: ex_mem.kind == K_HALT, rd: ex_mem.rd, wr: ex_mem.wr,
                  res: ex_mem.kind == K_LOAD ? dmem[ex_mem.res[DMEM_AW-1:0]] : ex_mem.res};
      ex_mem <= '{valid: id_ex.valid, kind: id_ex.kind, rd: id_ex.rd, wr: id_ex.wr, res: alu, sd: fb};
      if (flush || stall) id_ex <= '0;
      else id_ex <= id_dec;
      if (flush) begin
        pc <= id_ex.tgt;
        if_ir <= {OP_NOP, 26'd0};
        if_valid <= 1'b0;
      end else if (!stall) begin
        if (fetch_stop || id_kind == K_HALT) begin
          if_ir <= {OP_NOP, 26'd0};
          if_valid <= 1'b0;
        end else begin
          if_ir <= imem[pc];
          if_pc <= pc;
          if_valid <= 1'b1;
          pc <= pc + IMEM_AW'(1);
        end
      end
      fetch_stop <= fetch_stop || (id_kind == K_HALT && !flush);
      if (mem_wb.valid) bus.retired <= bus.retired + 32'(~&bus.retired);
      if (mem_wb.valid && mem_wb.halt) begin
        state <= S_HALTED;
        bus.running <= 1'b0;
        bus.halted <= 1'b1;
      end
    end
  end
endmodule

// File: doc/pipelined_core.md
PIPELINED_CORE -- requirements
Module: pipelined_core

Interface
REQ-001 Parameter DATA_W, default 32: datapath and register width; legal values 16, 32, 64.
REQ-002 Parameter IMEM_AW, default 8: instruction memory address width; depth is 2**IMEM_AW words of 32 bits.
REQ-003 Parameter DMEM_AW, default 8: data memory address width; depth is 2**DMEM_AW words of DATA_W bits.
REQ-004 Port clk1, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Ports imem_we (1), imem_addr (IMEM_AW), imem_wdata (32), inputs: instruction load port, honoured only when not RUN.
REQ-007 Port start, input, 1: single-cycle pulse; IDLE->RUN.
REQ-008 Ports dbg_sel (1: 0=regfile, 1=dmem), dbg_addr (max(5,DMEM_AW)), inputs: inspection read address.
REQ-009 Port dbg_rdata, output, DATA_W: combinational read of the selected register or dmem word.
REQ-010 Ports running (1), halted (1), retired (32), outputs: run state and count of retired instructions.

Function
REQ-011 Control FSM: IDLE -(start)-> RUN -(Halt retires)-> HALTED; HALTED is left only by reset. start in RUN or HALTED is ignored.
REQ-012 Five stages IF, ID, EX, MEM, WB on clk1 only; the instruction fetched in RUN cycle k writes back at the end of cycle k+4 when no stall or flush intervenes.
REQ-013 Encoding: opcode[31:26]; rs1[25:21]; rs2/rd[20:16]; R-type rd[15:11]; imm[15:0] sign-extended to DATA_W.
REQ-014 Opcodes: Nop 0x00, ADD 0x01, SUB 0x02, AND 0x03, OR 0x04, XOR 0x05, ADDI 0x06, SUBI 0x07, ANDI 0x08, ORI 0x09, Load 0x0A, Store 0x0B, shiftR 0x11, shiftL 0x12, branch 0x20, Jmp 0x21, Beq 0x22, Blt 0x23, Bgt 0x24, Halt 0x3F. Any other opcode executes as Nop.
REQ-015 Arithmetic wraps modulo 2**DATA_W; shift amount is imm[log2(DATA_W)-1:0]; shiftR is logical.
REQ-016 Load: rd[20:16] <= dmem[rs1+imm]. Store: dmem[rs1+imm] <= rs2[20:16]. Addresses are truncated to DMEM_AW bits.
REQ-017 Branch conditions: branch taken if rs1==0; Beq if rs1==rs2; Blt/Bgt use signed comparison. Target = branch address + imm, truncated to IMEM_AW bits.
REQ-018 Jmp is always taken; target = imm26 truncated to IMEM_AW bits.
REQ-019 Branches and Jmp resolve in EX; a taken branch flushes IF/ID and ID/EX to Nop (2-cycle penalty). An untaken branch costs no cycles.
REQ-020 Forwarding from EX/MEM and MEM/WB into EX operands, with EX/MEM taking priority; the regfile write is visible to the same-cycle ID read.
REQ-021 Load-use: when the ID instruction sources the rd of a Load in EX, stall PC and IF/ID for 1 cycle and insert a Nop into ID/EX.
REQ-022 Writes to r0 are discarded; r0 always reads 0.
REQ-023 Halt in ID stops fetch; older instructions drain. When Halt reaches WB: running=0, halted=1, no further state changes.
REQ-024 retired increments by 1 per non-bubble instruction reaching WB, Halt included; it saturates at 0xFFFFFFFF.
REQ-025 PC wraps from 2**IMEM_AW-1 to 0.
REQ-026 imem_we in RUN is ignored; imem_we in the same cycle as start writes first, then the core enters RUN.

Reset
REQ-027 Reset forces IDLE, PC=0, all pipeline registers to Nop, regfile=0, running=0, halted=0, retired=0, effective at any point including mid-run.
REQ-028 Reset does not modify imem or dmem contents.

Structure
REQ-029 Shared package proc_pkg holds opcode constants, operation-type enum, FSM state enum and instruction field positions.
REQ-030 Sub-module proc_regfile: 32 x DATA_W, two read ports, one write port with write-through bypass, and a debug read port.

Verification
REQ-031 ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; Halt -> r3=12 with no stall; halted rises in RUN cycle 8; retired=4.
REQ-032 ADDI r1,r0,9; Store r1->[r0+4]; Load r4<-[r0+4]; ADD r5,r4,r4; Halt -> exactly one stall cycle; r5=18; dmem[4]=9.
REQ-033 Beq r0,r0,+3 followed by two ADDI r6 -> both ADDIs flushed; r6=0; retired excludes them.
REQ-034 r1=3; loop SUBI r1,r1,1; branch-not-zero via Bgt r1,r0,-1; Halt -> r1=0; retired=1+3*2+1=8.
REQ-035 Reset asserted in RUN cycle 6 -> next cycle all outputs at reset values; imem preserved; rerun yields identical results.
REQ-036 DATA_W=16: SUBI r1,r0,1 -> 16'hFFFF; shiftL r2,r1,15 -> 16'h8000; Blt r2,r0 taken (signed).
